// File: rtl/smps_pkg.sv
// ----------------------------------------------------------------------------
// smps_pkg : shared widths, sequencer state encoding and slew helper. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package smps_pkg;

    localparam int TON_W = 11;
    localparam int DT_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STOP  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    // min(diff, step) on 12-bit operands; callers guarantee the result fits TON_W.
    function automatic logic [TON_W-1:0] step_amt(input logic [TON_W:0] diff,
                                                  input logic [TON_W:0] step);
        if (diff < step) begin
            return diff[TON_W-1:0];
        end
        return step[TON_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/period_timer.sv
// ----------------------------------------------------------------------------
// period_timer : switching-period counter, period tick and ramp-update tick. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module period_timer #(
    parameter int PERIOD   = 2000,
    parameter int PER_STEP = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_clear,
    output logic o_tick,
    output logic o_update
);

    localparam int CW = $clog2(PERIOD);
    localparam int SW = (PER_STEP > 1) ? $clog2(PER_STEP) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(PERIOD - 1);
    localparam logic [SW-1:0] S_LAST = SW'(PER_STEP - 1);

    logic [CW-1:0] cnt_q;
    logic [SW-1:0] step_q;

    assign o_tick   = (cnt_q == C_LAST);
    assign o_update = o_tick && (step_q == S_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            step_q <= '0;
        end else if (!i_run || i_clear) begin
            cnt_q  <= '0;
            step_q <= '0;
        end else if (o_tick) begin
            cnt_q  <= '0;
            step_q <= o_update ? '0 : step_q + SW'(1);
        end else begin
            cnt_q  <= cnt_q + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/dpwm_softstart_ctrl.sv
// ----------------------------------------------------------------------------
// dpwm_softstart_ctrl : soft-start/retune/soft-stop/fault sequencer feeding dpwm. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dpwm_softstart_ctrl
    import smps_pkg::*;
#(
    parameter int PERIOD   = 2000,
    parameter int TON_MAX  = 1900,
    parameter int STEP     = 4,
    parameter int PER_STEP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_fault,
    input  logic             i_fault_clr,
    input  logic [TON_W-1:0] i_ton_target,
    input  logic [DT_W-1:0]  i_dt1,
    input  logic [DT_W-1:0]  i_dt2,
    output logic             o_pwm_en,
    output logic [TON_W-1:0] o_ton,
    output logic [DT_W-1:0]  o_dt1,
    output logic [DT_W-1:0]  o_dt2,
    output logic             o_period_tick,
    output logic             o_at_target,
    output logic             o_fault
);

    localparam logic [TON_W-1:0] TON_MAX_V = TON_W'(TON_MAX);
    localparam logic [TON_W:0]   STEP_V    = (TON_W + 1)'(STEP);

    state_e           state_q, state_d;
    logic [TON_W-1:0] ton_q, ton_d;
    logic             pwm_en_q, pwm_en_d;
    logic [DT_W-1:0]  dt1_q, dt1_d;
    logic [DT_W-1:0]  dt2_q, dt2_d;

    logic             w_tick;
    logic             w_update;
    logic             w_run;
    logic             w_clear;
    logic [TON_W-1:0] w_tgt;
    logic [TON_W-1:0] w_ramp_ton;
    logic [TON_W-1:0] w_stop_ton;

    assign w_tgt = (i_ton_target > TON_MAX_V) ? TON_MAX_V : i_ton_target;

    // Differences are formed 12-bit so the slew never wraps past 0 or the target.
    always_comb begin
        w_ramp_ton = ton_q;
        if (ton_q < w_tgt) begin
            w_ramp_ton = ton_q + step_amt({1'b0, w_tgt} - {1'b0, ton_q}, STEP_V);
        end else if (ton_q > w_tgt) begin
            w_ramp_ton = ton_q - step_amt({1'b0, ton_q} - {1'b0, w_tgt}, STEP_V);
        end
    end

    assign w_stop_ton = ton_q - step_amt({1'b0, ton_q}, STEP_V);

    always_comb begin
        state_d  = state_q;
        ton_d    = ton_q;
        pwm_en_d = pwm_en_q;
        dt1_d    = dt1_q;
        dt2_d    = dt2_q;
        if (i_fault) begin
            state_d  = ST_FAULT;
            ton_d    = '0;
            pwm_en_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_enable) begin
                        state_d  = ST_RAMP;
                        pwm_en_d = 1'b1;
                        dt1_d    = i_dt1;
                        dt2_d    = i_dt2;
                    end else begin
                        pwm_en_d = 1'b0;
                    end
                end
                ST_RAMP: begin
                    if (!i_enable) begin
                        state_d = ST_STOP;
                    end else if (w_update) begin
                        ton_d = w_ramp_ton;
                        if (w_ramp_ton == w_tgt) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!i_enable) begin
                        state_d = ST_STOP;
                    end else if (w_update && (ton_q != w_tgt)) begin
                        state_d = ST_RAMP;
                    end
                end
                ST_STOP: begin
                    if (i_enable) begin
                        state_d = ST_RAMP;
                    end else if (w_update) begin
                        ton_d = w_stop_ton;
                        // pwm_en stays high here and drops on the following IDLE cycle.
                        if (w_stop_ton == '0) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_FAULT: begin
                    if (i_fault_clr && !i_enable) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    ton_d    = '0;
                    pwm_en_d = 1'b0;
                end
            endcase
        end
    end

    assign w_run   = (state_d == ST_RAMP) || (state_d == ST_RUN) || (state_d == ST_STOP);
    assign w_clear = (state_q == ST_IDLE);

    period_timer #(
        .PERIOD   (PERIOD),
        .PER_STEP (PER_STEP)
    ) u_period_timer (
        .clk      (clk),
        .rst      (rst),
        .i_run    (w_run),
        .i_clear  (w_clear),
        .o_tick   (w_tick),
        .o_update (w_update)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ton_q    <= '0;
            pwm_en_q <= 1'b0;
            dt1_q    <= '0;
            dt2_q    <= '0;
        end else begin
            state_q  <= state_d;
            ton_q    <= ton_d;
            pwm_en_q <= pwm_en_d;
            dt1_q    <= dt1_d;
            dt2_q    <= dt2_d;
        end
    end

    assign o_pwm_en      = pwm_en_q;
    assign o_ton         = ton_q;
    assign o_dt1         = dt1_q;
    assign o_dt2         = dt2_q;
    assign o_period_tick = w_tick;
    assign o_at_target   = (state_q == ST_RUN) && (ton_q == w_tgt);
    assign o_fault       = (state_q == ST_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_dpwm_softstart_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dpwm_softstart_ctrl : directed scenarios plus random stimulus against a cycle model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dpwm_softstart_ctrl;

    localparam int P  = 20;
    localparam int TM = 18;
    localparam int ST = 4;
    localparam int PS = 2;

    localparam int M_IDLE = 0, M_RAMP = 1, M_RUN = 2, M_STOP = 3, M_FLT = 4;

    logic        clk, rst;
    logic        en, flt, clr;
    logic [10:0] tgt;
    logic [4:0]  dt1, dt2;
    logic        o_pwm_en, o_period_tick, o_at_target, o_fault;
    logic [10:0] o_ton;
    logic [4:0]  o_dt1, o_dt2;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    dpwm_softstart_ctrl #(
        .PERIOD   (P),
        .TON_MAX  (TM),
        .STEP     (ST),
        .PER_STEP (PS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (en),
        .i_fault       (flt),
        .i_fault_clr   (clr),
        .i_ton_target  (tgt),
        .i_dt1         (dt1),
        .i_dt2         (dt2),
        .o_pwm_en      (o_pwm_en),
        .o_ton         (o_ton),
        .o_dt1         (o_dt1),
        .o_dt2         (o_dt2),
        .o_period_tick (o_period_tick),
        .o_at_target   (o_at_target),
        .o_fault       (o_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out at %0t", nm, $time);
    endtask

    // Reference: mode plus cycles-since-start; ticks and updates fall out of modulo arithmetic.
    int m_mode, m_ton, m_pwm, m_dt1, m_dt2, m_pos;

    always @(posedge clk or negedge rst) begin : p_model
        int md, tn, pw, d1, d2, ps, tg;
        bit act, upd;
        if (!rst) begin
            m_mode <= M_IDLE; m_ton <= 0; m_pwm <= 0;
            m_dt1  <= 0;      m_dt2 <= 0; m_pos <= 0;
        end else begin
            md = m_mode; tn = m_ton; pw = m_pwm; d1 = m_dt1; d2 = m_dt2;
            act = (m_mode == M_RAMP) || (m_mode == M_RUN) || (m_mode == M_STOP);
            upd = act && ((m_pos % (P * PS)) == (P * PS - 1));
            tg  = imin(int'(tgt), TM);
            if (flt) begin
                md = M_FLT; tn = 0; pw = 0;
            end else begin
                case (m_mode)
                    M_IDLE: if (en) begin md = M_RAMP; pw = 1; d1 = int'(dt1); d2 = int'(dt2); end
                            else pw = 0;
                    M_RAMP: if (!en) md = M_STOP;
                            else if (upd) begin
                                if (tn < tg) tn = tn + imin(ST, tg - tn);
                                else if (tn > tg) tn = tn - imin(ST, tn - tg);
                                if (tn == tg) md = M_RUN;
                            end
                    M_RUN:  if (!en) md = M_STOP;
                            else if (upd && tn != tg) md = M_RAMP;
                    M_STOP: if (en) md = M_RAMP;
                            else if (upd) begin
                                tn = tn - imin(ST, tn);
                                if (tn == 0) md = M_IDLE;
                            end
                    default: if (clr && !en) md = M_IDLE;
                endcase
            end
            ps = (act && (md == M_RAMP || md == M_RUN || md == M_STOP)) ? m_pos + 1 : 0;
            m_mode <= md; m_ton <= tn; m_pwm <= pw; m_dt1 <= d1; m_dt2 <= d2; m_pos <= ps;
        end
    end

    always @(negedge clk) begin : p_compare
        bit act;
        if (rst && chk_on) begin
            act = (m_mode == M_RAMP) || (m_mode == M_RUN) || (m_mode == M_STOP);
            chk("pwm_en", 32'(o_pwm_en), 32'(m_pwm));
            chk("ton", 32'(o_ton), 32'(m_ton));
            chk("dt1", 32'(o_dt1), 32'(m_dt1));
            chk("dt2", 32'(o_dt2), 32'(m_dt2));
            chk("period_tick", 32'(o_period_tick), 32'(act && (m_pos % P) == P - 1));
            chk("at_target", 32'(o_at_target),
                32'(m_mode == M_RUN && m_ton == imin(int'(tgt), TM)));
            chk("fault", 32'(o_fault), 32'(m_mode == M_FLT));
        end
    end

    task automatic at_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ton(input int v, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(o_ton) == v) return;
        end
        timeout(nm);
    endtask

    task automatic wait_at(input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_at_target) return;
        end
        timeout(nm);
    endtask

    initial begin
        rst = 1'b1; en = 0; flt = 0; clr = 0; tgt = '0; dt1 = 5'd3; dt2 = 5'd5;
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pwm_en", 32'(o_pwm_en), 0);
        chk("rst_ton", 32'(o_ton), 0);
        chk("rst_fault", 32'(o_fault), 0);
        chk("rst_dt1", 32'(o_dt1), 0);
        at_edge();
        rst = 1'b1;
        chk_on = 1;

        // Soft start to 10: 0 for 40 clk, then 4, 8, 10
        at_edge();
        tgt = 11'd10; en = 1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("ramp_ton0", 32'(o_ton), 0);
        chk("ramp_pwm", 32'(o_pwm_en), 1);
        @(posedge clk); @(negedge clk);
        chk("ramp_ton4", 32'(o_ton), 4);
        repeat (40) @(posedge clk); @(negedge clk);
        chk("ramp_ton8", 32'(o_ton), 8);
        repeat (40) @(posedge clk); @(negedge clk);
        chk("ramp_ton10", 32'(o_ton), 10);
        chk("ramp_at_target", 32'(o_at_target), 1);
        chk("dt1_latched", 32'(o_dt1), 3);

        // Dead time change in RUN is ignored
        at_edge();
        dt1 = 5'd9;
        repeat (5) @(posedge clk); @(negedge clk);
        chk("dt1_frozen", 32'(o_dt1), 3);

        // Clamp at 18, then retune down to 6
        at_edge();
        tgt = 11'd30;
        wait_at(600, "clamp_wait");
        chk("clamp_ton", 32'(o_ton), 18);
        at_edge();
        tgt = 11'd6;
        wait_at(600, "retune_wait");
        chk("retune_ton", 32'(o_ton), 6);

        // Soft stop from 10, pwm_en drops one clk after ton reaches 0
        at_edge();
        tgt = 11'd10;
        wait_at(600, "stop_pre_wait");
        at_edge();
        en = 0;
        wait_ton(0, 600, "stop_wait");
        chk("stop_pwm_hold", 32'(o_pwm_en), 1);
        @(negedge clk);
        chk("stop_pwm_drop", 32'(o_pwm_en), 0);

        // Re-enable mid stop resumes from current ton
        at_edge();
        en = 1;
        wait_at(600, "reen_pre_wait");
        at_edge();
        en = 0;
        wait_ton(6, 600, "reen_stop_wait");
        at_edge();
        en = 1;
        wait_at(600, "reen_wait");
        chk("reen_ton", 32'(o_ton), 10);

        // Fault mid ramp
        at_edge();
        en = 0;
        wait_ton(0, 600, "flt_pre_stop");
        repeat (2) at_edge();
        tgt = 11'd18; en = 1;
        wait_ton(8, 600, "flt_ramp_wait");
        at_edge();
        flt = 1;
        @(posedge clk); @(negedge clk);
        chk("flt_pwm", 32'(o_pwm_en), 0);
        chk("flt_ton", 32'(o_ton), 0);
        chk("flt_ind", 32'(o_fault), 1);
        at_edge();
        flt = 0; clr = 1;
        at_edge();
        clr = 0;
        @(negedge clk);
        chk("flt_clr_ignored", 32'(o_fault), 1);
        at_edge();
        en = 0;
        at_edge();
        clr = 1;
        at_edge();
        clr = 0;
        @(negedge clk);
        chk("flt_cleared", 32'(o_fault), 0);
        chk("flt_idle_pwm", 32'(o_pwm_en), 0);

        // Re-enable picks up the new dead time
        at_edge();
        en = 1; tgt = 11'd10;
        @(posedge clk); @(negedge clk);
        chk("dt1_relatch", 32'(o_dt1), 9);

        // Async reset mid ramp
        wait_ton(4, 600, "rst_ramp_wait");
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_pwm", 32'(o_pwm_en), 0);
        chk("arst_ton", 32'(o_ton), 0);
        chk("arst_dt1", 32'(o_dt1), 0);
        en = 0;
        at_edge();
        rst = 1'b1;
        repeat (3) @(posedge clk); @(negedge clk);
        chk("arst_idle_pwm", 32'(o_pwm_en), 0);
        chk("arst_idle_ton", 32'(o_ton), 0);

        // Random phase
        for (int it = 0; it < 1200; it++) begin
            at_edge();
            if ($urandom_range(0, 3) == 0) tgt = 11'($urandom_range(0, 31));
            en  = ($urandom_range(0, 9) != 0);
            flt = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) begin
                dt1 = 5'($urandom_range(0, 31));
                dt2 = 5'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 4) == 0) begin
                clr = 1;
                at_edge();
                clr = 0;
            end
            repeat ($urandom_range(1, 40)) at_edge();
        end

        at_edge();
        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
